// File: rtl/rot_dir_gen.sv
// rot_dir_gen: raster-scan generator of floor(offset + col*cos + row*sin) mod 2^OUT_W
module rot_dir_gen #(
    parameter int OUT_W  = 5,
    parameter int FRAC_W = 8,
    parameter int ROWS   = 16,
    parameter int COLS   = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic signed [FRAC_W+1:0]  cos_q,
    input  logic signed [FRAC_W+1:0]  sin_q,
    input  logic [OUT_W+FRAC_W-1:0]   offset_q,
    input  logic                      abort,
    output logic                      busy,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OUT_W-1:0]          out_dir,
    output logic [$clog2(ROWS)-1:0]   out_row,
    output logic [$clog2(COLS)-1:0]   out_col,
    output logic                      out_last,
    output logic                      done
);
    localparam int ACC_W = OUT_W + FRAC_W;
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam logic [RW-1:0] last_row = RW'(ROWS - 1);
    localparam logic [CW-1:0] last_col = CW'(COLS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_n;
    logic [ACC_W-1:0] cos_r, sin_r, row_acc, pix_acc;
    logic [RW-1:0]    row;
    logic [CW-1:0]    col;
    logic             go, accept, at_end;

    assign out_dir = pix_acc[ACC_W-1:FRAC_W];
    assign out_row = row;
    assign out_col = col;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // next state and handshake decode; abort suppresses acceptance of the current beat
    always_comb begin
        state_n   = state;
        go        = (state == IDLE) && start;
        at_end    = (row == last_row) && (col == last_col);
        out_valid = state == RUN;
        busy      = out_valid;
        out_last  = out_valid && at_end;
        done      = state == DONE;
        accept    = out_valid && out_ready && !abort;
        state_n   = go ? RUN :
                    (out_valid && abort) ? IDLE :
                    (accept && at_end) ? DONE :
                    done ? IDLE : state;
    end

    // angle latch and incremental accumulators; pix_acc holds its value past the last beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cos_r   <= '0;
            sin_r   <= '0;
            row_acc <= '0;
            pix_acc <= '0;
            row     <= '0;
            col     <= '0;
        end else if (go) begin
            cos_r   <= ACC_W'(cos_q);
            sin_r   <= ACC_W'(sin_q);
            row_acc <= offset_q;
            pix_acc <= offset_q;
            row     <= '0;
            col     <= '0;
        end else if (accept && !at_end) begin
            if (col == last_col) begin
                col     <= '0;
                row     <= row + 1'b1;
                row_acc <= row_acc + sin_r;
                pix_acc <= row_acc + sin_r;
            end else begin
                col     <= col + 1'b1;
                pix_acc <= pix_acc + cos_r;
            end
        end
    end
endmodule
